// File: rtl/hit_event_filter.sv
// Hit event filter for the missile collision detectors.
// The raw collision flags can stay high for many pixels in a frame. Each
// channel turns them into at most one registered pulse per frame boundary.
// After a report, the channel ignores new hits for COOLDOWN_FRAMES frames.

// state       | meaning
// ST_IDLE     | armed, waiting for a raw hit
// ST_HIT_SEEN | hit captured, report it at the next startOfFrame
// ST_COOLDOWN | reported, ignore raw hits for r_count more frame boundaries
module hit_event_channel #(
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic raw_hit,
    output logic hit_pulse,
    output logic cooldown
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HIT_SEEN = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam logic [7:0] LP_LOAD = 8'(COOLDOWN_FRAMES);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_count;
    logic [7:0] w_count_nxt;
    logic       r_pulse;
    logic       w_pulse_nxt;
    logic       r_cooldown;
    logic       w_cooldown_nxt;

    // State, frame counter and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ST_IDLE;
            r_count    <= 8'd0;
            r_pulse    <= 1'b0;
            r_cooldown <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_pulse    <= w_pulse_nxt;
            r_cooldown <= w_cooldown_nxt;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_pulse_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (raw_hit) begin
                    w_state_nxt = ST_HIT_SEEN;
                end
            end
            ST_HIT_SEEN: begin
                if (startOfFrame) begin
                    w_pulse_nxt = 1'b1;
                    w_count_nxt = LP_LOAD;
                    // A zero-length cooldown re-arms straight away.
                    w_state_nxt = (LP_LOAD == 8'd0) ? ST_IDLE : ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                if (startOfFrame) begin
                    if (r_count == 8'd1) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_count_nxt = r_count - 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Registered copy of the state decode, so cooldown is high exactly in COOLDOWN.
        w_cooldown_nxt = (w_state_nxt == ST_COOLDOWN);
    end

    assign hit_pulse = r_pulse;
    assign cooldown  = r_cooldown;

endmodule

// Top level: two independent channels sharing the frame strobe.
module hit_event_filter #(
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic collision_aliens_missile_raw,
    input  logic collision_ship_missile_raw,
    output logic collision_aliens_missile,
    output logic collision_ship_missile,
    output logic aliens_cooldown,
    output logic ship_cooldown
);

    hit_event_channel #(
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
    ) u_aliens (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .raw_hit     (collision_aliens_missile_raw),
        .hit_pulse   (collision_aliens_missile),
        .cooldown    (aliens_cooldown)
    );

    hit_event_channel #(
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
    ) u_ship (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .raw_hit     (collision_ship_missile_raw),
        .hit_pulse   (collision_ship_missile),
        .cooldown    (ship_cooldown)
    );

endmodule

// File: tb/tb_hit_event_filter.sv
// Bench for hit_event_filter: two instances (cooldown 8 and cooldown 0)
// share one stimulus stream and are checked every cycle against a
// frame-boundary model, plus a few literal directed expectations.
module tb_hit_event_filter;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic sof = 1'b0;
    logic raw_al = 1'b0;
    logic raw_sh = 1'b0;

    logic hit_al8, hit_sh8, cd_al8, cd_sh8;
    logic hit_al0, hit_sh0, cd_al0, cd_sh0;

    int n_cmp = 0;
    int n_mis = 0;

    // Model state, index [dut][channel]: dut 0 = cooldown 8, dut 1 = cooldown 0;
    // channel 0 = aliens, channel 1 = ship.
    int nb = 0;                 // frame boundaries seen so far
    bit m_pend [2][2];          // a hit is waiting for the next boundary
    bit m_has  [2][2];          // a pulse has been reported since reset
    int m_p    [2][2];          // boundary index of the last report
    bit exp_hit[2][2];
    bit exp_cd [2][2];
    int cnt_hit[2][2];          // observed DUT pulses
    logic act_h[2][2];
    logic act_c[2][2];

    hit_event_filter #(.COOLDOWN_FRAMES(8)) u_dut8 (
        .clk                         (clk),
        .resetN                      (resetN),
        .startOfFrame                (sof),
        .collision_aliens_missile_raw(raw_al),
        .collision_ship_missile_raw  (raw_sh),
        .collision_aliens_missile    (hit_al8),
        .collision_ship_missile      (hit_sh8),
        .aliens_cooldown             (cd_al8),
        .ship_cooldown               (cd_sh8)
    );

    hit_event_filter #(.COOLDOWN_FRAMES(0)) u_dut0 (
        .clk                         (clk),
        .resetN                      (resetN),
        .startOfFrame                (sof),
        .collision_aliens_missile_raw(raw_al),
        .collision_ship_missile_raw  (raw_sh),
        .collision_aliens_missile    (hit_al0),
        .collision_ship_missile      (hit_sh0),
        .aliens_cooldown             (cd_al0),
        .ship_cooldown               (cd_sh0)
    );

    always #5 clk = ~clk;

    function automatic int cf(int d);
        return (d == 0) ? 8 : 0;
    endfunction

    task automatic chk(string nm, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a hit is accepted when the channel is open (no pending hit and
    // at least COOLDOWN_FRAMES boundaries have passed since the last report);
    // a pending hit is reported on the cycle after the next boundary.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    m_pend[d][c]  = 1'b0;
                    m_has[d][c]   = 1'b0;
                    exp_hit[d][c] = 1'b0;
                    exp_cd[d][c]  = 1'b0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    exp_hit[d][c] = 1'b0;
                    if (m_pend[d][c] && sof) begin
                        exp_hit[d][c] = 1'b1;
                        m_pend[d][c]  = 1'b0;
                        m_has[d][c]   = 1'b1;
                        m_p[d][c]     = nb + 1;
                    end else if (!m_pend[d][c] && ((c == 0) ? raw_al : raw_sh) &&
                                 (!m_has[d][c] || nb >= m_p[d][c] + cf(d))) begin
                        m_pend[d][c] = 1'b1;
                    end
                end
            end
            if (sof) nb++;
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    exp_cd[d][c] = m_has[d][c] && !m_pend[d][c] && (nb < m_p[d][c] + cf(d));
                end
            end
        end
    end

    // Compare process: every output of both instances on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            act_h[0][0] = hit_al8; act_h[0][1] = hit_sh8;
            act_h[1][0] = hit_al0; act_h[1][1] = hit_sh0;
            act_c[0][0] = cd_al8;  act_c[0][1] = cd_sh8;
            act_c[1][0] = cd_al0;  act_c[1][1] = cd_sh0;
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 2; c++) begin
                    chk($sformatf("hit[cf%0d][ch%0d]", cf(d), c), act_h[d][c], exp_hit[d][c]);
                    chk($sformatf("cooldown[cf%0d][ch%0d]", cf(d), c), act_c[d][c], exp_cd[d][c]);
                    if (act_h[d][c] === 1'b1) cnt_hit[d][c]++;
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(int n);
        resetN = 1'b0;
        sof = 1'b0;
        raw_al = 1'b0;
        raw_sh = 1'b0;
        tick(n);
        resetN = 1'b1;
        tick(2);
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_al8"}, hit_al8 | cd_al8, 1'b0);
        chk({nm, "_sh8"}, hit_sh8 | cd_sh8, 1'b0);
        chk({nm, "_al0"}, hit_al0 | cd_al0, 1'b0);
        chk({nm, "_sh0"}, hit_sh0 | cd_sh0, 1'b0);
    endtask

    initial begin
        int s_al8, s_sh8, s_al0, s_sh0;
        int flen, fcnt, b_al, b_sh;

        // Reset state.
        resetN = 1'b0;
        tick(3);
        chk_all_zero("reset");
        resetN = 1'b1;
        tick(2);

        // Long raw burst within one frame gives a single one-cycle pulse.
        raw_al = 1'b1;
        tick(40);
        raw_al = 1'b0;
        tick(50);
        sof = 1'b1;
        tick(1);
        sof = 1'b0;
        chk("burst_pulse8", hit_al8, 1'b1);
        chk("burst_cd8", cd_al8, 1'b1);
        chk("burst_pulse0", hit_al0, 1'b1);
        chk("burst_cd0", cd_al0, 1'b0);
        chk("burst_ship", hit_sh8, 1'b0);
        chk("burst_model", exp_hit[0][0], 1'b1);
        tick(1);
        chk("burst_width", hit_al8, 1'b0);
        chk("burst_cd_hold", cd_al8, 1'b1);

        // Raw high every frame on both channels: 19 boundaries.
        do_reset(2);
        s_al8 = cnt_hit[0][0]; s_sh8 = cnt_hit[0][1];
        s_al0 = cnt_hit[1][0]; s_sh0 = cnt_hit[1][1];
        for (int f = 0; f < 19; f++) begin
            raw_al = 1'b1;
            raw_sh = 1'b1;
            tick(3);
            raw_al = 1'b0;
            raw_sh = 1'b0;
            tick(10);
            sof = 1'b1;
            tick(1);
            sof = 1'b0;
        end
        chk("every9_al8", (cnt_hit[0][0] - s_al8) == 3, 1'b1);
        chk("every9_sh8", (cnt_hit[0][1] - s_sh8) == 3, 1'b1);
        chk("every1_al0", (cnt_hit[1][0] - s_al0) == 19, 1'b1);
        chk("every1_sh0", (cnt_hit[1][1] - s_sh0) == 19, 1'b1);
        chk("last_pulse_al8", hit_al8, 1'b1);
        chk("last_pulse_sh8", hit_sh8, 1'b1);

        // Raw and startOfFrame together: no pulse until the next boundary.
        do_reset(2);
        tick(5);
        raw_al = 1'b1;
        sof = 1'b1;
        tick(1);
        raw_al = 1'b0;
        sof = 1'b0;
        chk("same_cycle_nopulse8", hit_al8, 1'b0);
        chk("same_cycle_nopulse0", hit_al0, 1'b0);
        tick(20);
        sof = 1'b1;
        tick(1);
        sof = 1'b0;
        chk("same_cycle_next8", hit_al8, 1'b1);
        chk("same_cycle_next0", hit_al0, 1'b1);

        // Reset during HIT_SEEN discards the hit.
        do_reset(2);
        raw_sh = 1'b1;
        tick(5);
        raw_sh = 1'b0;
        tick(3);
        resetN = 1'b0;
        tick(3);
        chk_all_zero("mid_reset");
        resetN = 1'b1;
        tick(5);
        sof = 1'b1;
        tick(1);
        sof = 1'b0;
        chk("discard_sh8", hit_sh8, 1'b0);
        chk("discard_sh0", hit_sh0, 1'b0);
        tick(5);
        raw_sh = 1'b1;
        tick(1);
        raw_sh = 1'b0;
        tick(5);
        sof = 1'b1;
        tick(1);
        sof = 1'b0;
        chk("rearm_sh8", hit_sh8, 1'b1);
        chk("rearm_cd8", cd_sh8, 1'b1);
        chk("rearm_sh0", hit_sh0, 1'b1);

        // Random frames, bursts and occasional resets.
        flen = $urandom_range(4, 25);
        fcnt = 0;
        b_al = 0;
        b_sh = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                resetN = 1'b0;
            end else if (!resetN && $urandom_range(0, 2) == 0) begin
                resetN = 1'b1;
            end
            if (b_al > 0) b_al--;
            else if ($urandom_range(0, 11) == 0) b_al = $urandom_range(1, 40);
            if (b_sh > 0) b_sh--;
            else if ($urandom_range(0, 11) == 0) b_sh = $urandom_range(1, 40);
            raw_al = (b_al > 0);
            raw_sh = (b_sh > 0);
            fcnt++;
            if (fcnt >= flen) begin
                sof = 1'b1;
                fcnt = 0;
                flen = $urandom_range(4, 25);
            end else begin
                sof = 1'b0;
            end
            tick(1);
        end
        resetN = 1'b1;
        sof = 1'b0;
        raw_al = 1'b0;
        raw_sh = 1'b0;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
